datapath: RTL and testbench

- Single-cycle MIPS-style datapath for the processor core. Control signals come from the controller; the instruction word comes from the instruction memory.
- Internals: program counter, 32x32 register file, sign extender, ALU ("ULA"), branch adder and the operand/result muxes.
- Exposes the PC, the ALU result, the store data and the zero flag. Accepts read data from the external data memory.

---
 rtl/datapath.sv | 103 ++++++++++
 tb/tb_datapath.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Single-cycle MIPS-style datapath: PC, 32x32 register file, sign extend,
// ALU ("ULA"), branch adder and operand/result muxes. No memories inside.

module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] rf [0:31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      rf[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents; there is no write-to-read bypass.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf[ra2];
endmodule

module datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic        memtoreg,
  input  logic        pcsrc,
  input  logic        ULAsrc,
  input  logic        regdst,
  input  logic        regwrite,
  input  logic        memread,
  input  logic [2:0]  ULAcontrol,
  output logic        zero,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] ULAout,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);
  logic [31:0] signimm;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [31:0] result;
  logic [31:0] pcplus4;
  logic [31:0] pcbranch;
  logic [31:0] pcnext;
  logic [4:0]  writereg;
  logic        unused_bits;

  // The opcode field and memread are decoded by the controller, not here.
  assign unused_bits = ^{memread, instr[31:26]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else       pc <= pcnext;
  end

  assign pcplus4  = pc + 32'd4;
  assign signimm  = {{16{instr[15]}}, instr[15:0]};
  assign pcbranch = pcplus4 + {signimm[29:0], 2'b00};
  assign pcnext   = pcsrc ? pcbranch : pcplus4;

  assign writereg = regdst ? instr[15:11] : instr[20:16];
  assign result   = memtoreg ? readdata : ULAout;

  regfile rf (
    .clk   (clk),
    .reset (reset),
    .we    (regwrite),
    .ra1   (instr[25:21]),
    .ra2   (instr[20:16]),
    .wa    (writereg),
    .wd    (result),
    .rd1   (srca),
    .rd2   (writedata)
  );

  assign srcb = ULAsrc ? signimm : writedata;

  always_comb begin
    ULAout = '0;
    case (ULAcontrol)
      3'b000: ULAout = srca & srcb;
      3'b001: ULAout = srca | srcb;
      3'b010: ULAout = srca + srcb;
      3'b011: ULAout = '0;
      3'b100: ULAout = srca & ~srcb;
      3'b101: ULAout = srca | ~srcb;
      3'b110: ULAout = srca - srcb;
      3'b111: ULAout = {31'd0, ($signed(srca) < $signed(srcb))};
      default: ULAout = '0;
    endcase
  end

  assign zero = (ULAout == 32'd0);
endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: instruction sequences with hand-computed
// register, PC, ALU and flag values.

module tb_datapath;
  logic        clk = 1'b0;
  logic        reset;
  logic        memtoreg, pcsrc, ULAsrc, regdst, regwrite, memread;
  logic [2:0]  ULAcontrol;
  logic        zero;
  logic [31:0] pc, instr, ULAout, writedata, readdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pc;

  datapath dut (
    .clk        (clk),
    .reset      (reset),
    .memtoreg   (memtoreg),
    .pcsrc      (pcsrc),
    .ULAsrc     (ULAsrc),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .memread    (memread),
    .ULAcontrol (ULAcontrol),
    .zero       (zero),
    .pc         (pc),
    .instr      (instr),
    .ULAout     (ULAout),
    .writedata  (writedata),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;

  // Inputs are applied 1 time unit after a rising edge and sampled before the next one.
  task automatic drive(input logic [31:0] i, input logic rd, input logic src,
                       input logic m2r, input logic rw, input logic ps,
                       input logic [2:0] ac, input logic [31:0] rdata);
    instr = i; regdst = rd; ULAsrc = src; memtoreg = m2r;
    regwrite = rw; pcsrc = ps; ULAcontrol = ac; readdata = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1; memread = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h expected 00000000", pc);
    end
    bad = 0;
    for (int r = 0; r < 32; r++) if (dut.rf.rf[r] !== 32'h0) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_regs: %0d nonzero registers, expected 0", bad);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_pc = 32'h0;
    @(posedge clk); #1;
    exp_pc = 32'h4;
    checks++;
    if (pc !== exp_pc) begin
      errors++; $display("FAIL pc_after_release: got %h expected %h", pc, exp_pc);
    end
  endtask

  task automatic test_addi();
    drive(32'h20020005, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0);
    checks++;
    if (ULAout !== 32'h5) begin
      errors++; $display("FAIL addi_ulaout: got %h expected 00000005", ULAout);
    end
    tick(); exp_pc += 4;
    drive(32'h2003000C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0);
    tick(); exp_pc += 4;
    checks++;
    if (dut.rf.rf[2] !== 32'h5 || dut.rf.rf[3] !== 32'hC) begin
      errors++; $display("FAIL addi_regs: got r2=%h r3=%h expected 5 and c", dut.rf.rf[2], dut.rf.rf[3]);
    end
    checks++;
    if (pc !== exp_pc) begin
      errors++; $display("FAIL addi_pc: got %h expected %h", pc, exp_pc);
    end
  endtask

  task automatic test_rtype();
    logic [31:0] ins [5] = '{32'h00432020, 32'h00822822, 32'h00823024, 32'h00823825, 32'h0043402A};
    logic [2:0]  ops [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    logic [31:0] exp [5] = '{32'h11, 32'hC, 32'h1, 32'h15, 32'h1};
    for (int k = 0; k < 5; k++) begin
      drive(ins[k], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ops[k], 32'h0);
      tick(); exp_pc += 4;
      checks++;
      if (dut.rf.rf[4 + k] !== exp[k]) begin
        errors++; $display("FAIL rtype_r%0d: got %h expected %h", 4 + k, dut.rf.rf[4 + k], exp[k]);
      end
    end
  endtask

  task automatic test_store_load();
    drive(32'hAC040004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'hDEAD);
    checks++;
    if (ULAout !== 32'h4 || writedata !== 32'h11) begin
      errors++; $display("FAIL sw_outputs: got addr=%h data=%h expected 4 and 11", ULAout, writedata);
    end
    tick(); exp_pc += 4;
    checks++;
    if (dut.rf.rf[4] !== 32'h11 || dut.rf.rf[0] !== 32'h0) begin
      errors++; $display("FAIL sw_no_write: got r4=%h r0=%h expected 11 and 0", dut.rf.rf[4], dut.rf.rf[0]);
    end
    drive(32'h8C0A0004, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h11);
    checks++;
    if (dut.rf.rf[10] !== 32'h0) begin
      errors++; $display("FAIL lw_before_edge: got %h expected 0", dut.rf.rf[10]);
    end
    tick(); exp_pc += 4;
    checks++;
    if (dut.rf.rf[10] !== 32'h11) begin
      errors++; $display("FAIL lw_r10: got %h expected 00000011", dut.rf.rf[10]);
    end
  endtask

  task automatic test_reg0_bypass();
    drive(32'h20000007, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0);
    tick(); exp_pc += 4;
    checks++;
    if (dut.rf.rf[0] !== 32'h0) begin
      errors++; $display("FAIL r0_write: got %h expected 0", dut.rf.rf[0]);
    end
    // addi $2,$2,1: rt read must show the old value until the edge
    drive(32'h20420001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0);
    checks++;
    if (ULAout !== 32'h6 || writedata !== 32'h5) begin
      errors++; $display("FAIL no_bypass: got alu=%h wd=%h expected 6 and 5", ULAout, writedata);
    end
    tick(); exp_pc += 4;
    checks++;
    if (dut.rf.rf[2] !== 32'h6) begin
      errors++; $display("FAIL r2_update: got %h expected 00000006", dut.rf.rf[2]);
    end
  endtask

  task automatic test_alu_misc();
    // rs=r4 (0x11), rt=r2 (0x6), no write
    drive(32'h00820000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 32'h0);
    checks++;
    if (ULAout !== 32'h11) begin
      errors++; $display("FAIL andnot: got %h expected 00000011", ULAout);
    end
    drive(32'h00820000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 32'h0);
    checks++;
    if (ULAout !== 32'hFFFFFFF9) begin
      errors++; $display("FAIL ornot: got %h expected fffffff9", ULAout);
    end
    drive(32'h00820000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 32'h0);
    checks++;
    if (ULAout !== 32'h0 || zero !== 1'b1) begin
      errors++; $display("FAIL zero_op: got %h z=%b expected 0 z=1", ULAout, zero);
    end
    drive(32'h0080FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 32'h0);
    checks++;
    if (ULAout !== 32'h0) begin
      errors++; $display("FAIL slt_signed: got %h expected 0", ULAout);
    end
    drive(32'h0080FFEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0);
    checks++;
    if (ULAout !== 32'h0 || zero !== 1'b1) begin
      errors++; $display("FAIL add_wrap: got %h z=%b expected 0 z=1", ULAout, zero);
    end
    drive(32'h00820000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 32'h0);
    checks++;
    if (ULAout !== 32'hB || zero !== 1'b0) begin
      errors++; $display("FAIL sub_nonzero: got %h z=%b expected b z=0", ULAout, zero);
    end
    tick(); exp_pc += 4;
  endtask

  task automatic test_branch();
    // beq $3,$3,-1: target = pc+4-4
    drive(32'h1063FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110, 32'h0);
    checks++;
    if (zero !== 1'b1) begin
      errors++; $display("FAIL branch_zero: got %b expected 1", zero);
    end
    tick();
    checks++;
    if (pc !== exp_pc) begin
      errors++; $display("FAIL branch_back: got %h expected %h", pc, exp_pc);
    end
    drive(32'h10630002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110, 32'h0);
    tick(); exp_pc += 32'd12;
    checks++;
    if (pc !== exp_pc) begin
      errors++; $display("FAIL branch_fwd: got %h expected %h", pc, exp_pc);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL async_pc: got %h expected 00000000", pc);
    end
    bad = 0;
    for (int r = 0; r < 32; r++) if (dut.rf.rf[r] !== 32'h0) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL async_regs: %0d nonzero registers, expected 0", bad);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype();
    test_store_load();
    test_reg0_bypass();
    test_alu_misc();
    test_branch();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
